adder_seq_ctrl: RTL

//   Sequencer that reuses one SLICE-bit adder slice to perform a WIDTH-bit add.
//   - Processes one slice per cycle, LSB slice first, rippling the carry through a register.
//   - Replaces a wide combinational adder tree (8b -> 16b -> 32b) with a single shared slice.
//   - Sits between an operand producer and a result consumer, both using valid/ready handshakes.

---
 rtl/adder_pkg.sv | 19 +
 rtl/adder_slice_c.sv | 14 +
 rtl/adder_seq_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the sequential slice adder: FSM encodings and sizing helpers.
package adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;
  localparam int NSLICE    = DEF_WIDTH / DEF_SLICE;
  localparam int IDX_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int idx_width_f(input int width, input int slice);
    int n;
    n = width / slice;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_slice_c.sv
// Combinational W-bit adder slice with carry in/out, shared across all slices of an add.
module adder_slice_c #(
  parameter int W = adder_pkg::DEF_SLICE
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/adder_seq_ctrl.sv
// WIDTH-bit adder built from one SLICE-bit slice, one slice per cycle, LSB first.
// Optional signed-overflow output enabled by defining ADDER_SEQ_OVF_EN.
module adder_seq_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef ADDER_SEQ_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);

  localparam int N_SL  = WIDTH / SLICE;
  localparam int IW    = idx_width_f(WIDTH, SLICE);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_SL - 1);

  if ((WIDTH % SLICE) != 0 || N_SL < 2) begin : g_cfg_err
    $error("adder_seq_ctrl: WIDTH must be a multiple of SLICE with at least 2 slices");
  end

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [SLICE-1:0] sl_s;
  logic             sl_co;

  adder_slice_c #(.W(SLICE)) u_slice (
    .a  (a_q[idx_q*SLICE +: SLICE]),
    .b  (b_q[idx_q*SLICE +: SLICE]),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );

  // Next-state and datapath update for the accept / ripple / retire sequence
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*SLICE +: SLICE] = sl_s;
        carry_d = sl_co;
        if (idx_q == IDX_LAST) begin
          cout_d  = sl_co;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef ADDER_SEQ_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow, captured alongside the top slice using its sum MSB
  always_comb begin
    if (state_q == ST_RUN && idx_q == IDX_LAST) begin
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_s[SLICE-1] != a_q[WIDTH-1]);
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule
